// File: rtl/ahb_transfer_ctrl.sv
// ahb_transfer_ctrl
//   AHB-Lite slave front end for the data-buffer peripheral. It captures the
//   address phase into haddr_reg/hsize_reg/hwrite_reg, screens each transfer
//   for size/alignment/map/read-only errors, stalls writes while the data
//   buffer is full (bounded by MAX_WAIT), and produces the two-cycle ERROR
//   response.
//
//   Ports:
//     clk, rst          - clock, synchronous active-high reset
//     hsel, htrans,
//     haddr, hsize,
//     hwrite, hready    - AHB-Lite address phase inputs
//     buffer_full       - data buffer cannot accept a write
//     haddr_reg,
//     hsize_reg,
//     hwrite_reg        - captured address phase, feeds the address decoder
//     data_valid        - one-cycle commit strobe for the captured transfer
//     hreadyout, hresp  - slave ready and ERROR response
module ahb_transfer_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsel,
  input  logic [1:0] htrans,
  input  logic [3:0] haddr,
  input  logic [1:0] hsize,
  input  logic       hwrite,
  input  logic       hready,
  input  logic       buffer_full,
  output logic [3:0] haddr_reg,
  output logic [1:0] hsize_reg,
  output logic       hwrite_reg,
  output logic       data_valid,
  output logic       hreadyout,
  output logic       hresp
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [7:0] wait_cnt;
  logic       capture;
  logic       bad;
  logic       stall;
  logic       expired;

  // htrans[0] only separates SEQ from NONSEQ (or BUSY from IDLE); not needed here
  logic unused_htrans0;
  assign unused_htrans0 = htrans[0];

  always_comb begin
    capture = 1'b0;
    if (state == ST_IDLE || state == ST_DATA || state == ST_ERR2)
      capture = hsel && htrans[1] && hready && hreadyout;

    bad = (hsize == 2'd3)
        || (hsize == 2'd1 && haddr[0])
        || (hsize == 2'd2 && haddr[1:0] != 2'b00)
        || (haddr inside {4'h9, 4'hA, 4'hB, 4'hE, 4'hF})
        || (hwrite && (haddr inside {[4'h4:4'h8]}));

    stall   = hwrite && (haddr <= 4'd3) && buffer_full;
    expired = (wait_cnt == 8'(MAX_WAIT - 1));

    nxt = state;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (capture) begin
          if (bad)        nxt = ST_ERR1;
          else if (stall) nxt = ST_WAIT;
          else            nxt = ST_DATA;
        end else begin
          nxt = ST_IDLE;
        end
      end
      // buffer draining takes priority over timeout on the same cycle
      ST_WAIT: begin
        if (!buffer_full)  nxt = ST_DATA;
        else if (expired)  nxt = ST_ERR1;
        else               nxt = ST_WAIT;
      end
      ST_ERR1: nxt = ST_ERR2;
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      haddr_reg  <= '0;
      hsize_reg  <= '0;
      hwrite_reg <= 1'b0;
      data_valid <= 1'b0;
      hreadyout  <= 1'b1;
      hresp      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state      <= nxt;
      data_valid <= (nxt == ST_DATA);
      hreadyout  <= (nxt != ST_WAIT) && (nxt != ST_ERR1);
      hresp      <= (nxt == ST_ERR1) || (nxt == ST_ERR2);

      if (capture) begin
        haddr_reg  <= haddr;
        hsize_reg  <= hsize;
        hwrite_reg <= hwrite;
      end

      // cleared on entry to WAIT, counts each further stalled cycle
      if (nxt == ST_WAIT)
        wait_cnt <= (state == ST_WAIT) ? wait_cnt + 8'd1 : '0;
    end
  end

endmodule

// File: tb/tb_ahb_transfer_ctrl.sv
// tb_ahb_transfer_ctrl
//   Scoreboard bench: the driver pushes the expected outcome of every
//   captured transfer (commit or error, captured fields, stall length); a
//   separate monitor pops on each data_valid or ERROR response and compares.
module tb_ahb_transfer_ctrl;

  localparam int MAX_WAIT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsel;
  logic [1:0] htrans;
  logic [3:0] haddr;
  logic [1:0] hsize;
  logic       hwrite;
  logic       hready;
  logic       buffer_full;
  logic [3:0] haddr_reg;
  logic [1:0] hsize_reg;
  logic       hwrite_reg;
  logic       data_valid;
  logic       hreadyout;
  logic       hresp;

  ahb_transfer_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .haddr(haddr),
    .hsize(hsize), .hwrite(hwrite), .hready(hready), .buffer_full(buffer_full),
    .haddr_reg(haddr_reg), .hsize_reg(hsize_reg), .hwrite_reg(hwrite_reg),
    .data_valid(data_valid), .hreadyout(hreadyout), .hresp(hresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [1:0] s;
    logic       w;
    bit         err;
    int         waits;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;
  bit   exp_err2 = 1'b0;
  int   waits_seen = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference rules for an erroring access
  function automatic bit is_err(input int a, input int s, input bit w);
    if (s == 3) return 1'b1;
    if (s == 1 && (a % 2) != 0) return 1'b1;
    if (s == 2 && (a % 4) != 0) return 1'b1;
    if (a == 9 || a == 10 || a == 11 || a == 14 || a == 15) return 1'b1;
    if (w && a >= 4 && a <= 8) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arbitrary inputs for cycles where the slave must not capture
  task automatic set_junk();
    hsel   = 1'($urandom);
    htrans = 2'($urandom);
    hready = 1'($urandom);
    haddr  = 4'($urandom);
    hsize  = 2'($urandom);
    hwrite = 1'($urandom);
  endtask

  // Non-capturing bus cycle: 0 unselected, 1 BUSY, 2 IDLE, 3 hready low
  task automatic do_idle(input int kind);
    set_junk();
    buffer_full = 1'($urandom);
    case (kind)
      0: hsel = 1'b0;
      1: begin hsel = 1'b1; htrans = 2'd1; hready = 1'b1; end
      2: begin hsel = 1'b1; htrans = 2'd0; hready = 1'b1; end
      default: begin hsel = 1'b1; htrans = 2'd2; hready = 1'b0; end
    endcase
    step();
  endtask

  // One captured transfer from a ready slave. stall_len < 0: no stall;
  // otherwise buffer_full stays high for stall_len WAIT cycles then drops.
  task automatic do_xfer(input int a, input int s, input bit w, input int stall_len);
    exp_t e;
    bit   err, stall, bf_rel;
    int   waits;
    err    = is_err(a, s, w);
    bf_rel = w && a <= 3 && !err;
    stall  = bf_rel && stall_len >= 0;
    waits  = 0;
    hsel   = 1'b1;
    htrans = {1'b1, 1'($urandom)};
    hready = 1'b1;
    haddr  = 4'(a);
    hsize  = 2'(s);
    hwrite = w;
    buffer_full = stall ? 1'b1 : (bf_rel ? 1'b0 : 1'($urandom));
    if (stall) begin
      waits = (stall_len >= MAX_WAIT) ? MAX_WAIT : stall_len + 1;
      err   = (stall_len >= MAX_WAIT);
    end
    e.a = 4'(a); e.s = 2'(s); e.w = w; e.err = err; e.waits = waits;
    q.push_back(e);
    step();
    for (int i = 0; i < waits; i++) begin
      set_junk();
      buffer_full = (i < stall_len);
      step();
    end
    if (err) begin
      set_junk();
      buffer_full = 1'($urandom);
      step();
    end
  endtask

  // Monitor: pops on commit strobe or first ERROR cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_err2) begin
        check("err2_hresp", hresp, 1);
        check("err2_hreadyout", hreadyout, 1);
        check("err2_dv", data_valid, 0);
        exp_err2 = 1'b0;
      end else if (data_valid || hresp) begin
        if (q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("event_is_err", hresp, int'(e.err));
          check("event_hreadyout", hreadyout, data_valid ? 1 : 0);
          check("event_regs", {haddr_reg, hsize_reg, hwrite_reg}, {e.a, e.s, e.w});
          check("event_waits", waits_seen, e.waits);
          if (hresp) exp_err2 = 1'b1;
        end
        waits_seen = 0;
      end else if (!hreadyout) begin
        waits_seen++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    hsel = 1'b0; htrans = 2'd0; haddr = '0; hsize = '0; hwrite = 1'b0;
    hready = 1'b1; buffer_full = 1'b0;
    step(); step();
    check("rst_hreadyout", hreadyout, 1);
    check("rst_hresp", hresp, 0);
    check("rst_dv", data_valid, 0);
    check("rst_regs", {haddr_reg, hsize_reg, hwrite_reg}, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed: clean write, back-to-back reads, non-captures, errors, stalls
    do_xfer(0, 2, 1'b1, -1);
    do_idle(2);
    do_xfer(4, 1, 1'b0, -1);
    do_xfer(6, 1, 1'b0, -1);
    do_idle(1);
    do_idle(3);
    do_xfer(5, 0, 1'b1, -1);
    do_xfer(2, 2, 1'b0, -1);
    do_xfer(0, 3, 1'b0, -1);
    do_xfer(14, 0, 1'b0, -1);
    do_xfer(0, 2, 1'b1, 2);
    do_xfer(0, 2, 1'b1, MAX_WAIT);
    do_xfer(1, 0, 1'b1, MAX_WAIT - 1);
    do_xfer(3, 0, 1'b1, 0);
    do_idle(0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        int a, s, l;
        bit w;
        a = $urandom_range(0, 15);
        s = $urandom_range(0, 3);
        w = 1'($urandom);
        l = ($urandom_range(0, 2) == 0) ? $urandom_range(0, MAX_WAIT + 2) : -1;
        do_xfer(a, s, w, l);
      end else begin
        do_idle($urandom_range(0, 3));
      end
    end
    do_idle(0);
    do_idle(0);

    // Reset while stalled
    mon_en = 1'b0;
    hsel = 1'b1; htrans = 2'd2; hready = 1'b1;
    haddr = 4'd2; hsize = 2'd0; hwrite = 1'b1; buffer_full = 1'b1;
    step();
    set_junk(); buffer_full = 1'b1;
    step();
    check("wait_hreadyout", hreadyout, 0);
    rst = 1'b1;
    step();
    check("wrst_hreadyout", hreadyout, 1);
    check("wrst_hresp", hresp, 0);
    check("wrst_haddr_reg", haddr_reg, 0);
    check("wrst_dv", data_valid, 0);
    rst = 1'b0;
    q.delete();
    waits_seen = 0;
    exp_err2 = 1'b0;
    do_idle(0);
    mon_en = 1'b1;

    do_xfer(8, 0, 1'b0, -1);
    do_xfer(0, 1, 1'b1, 1);
    do_idle(0);
    do_idle(0);
    do_idle(0);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
